sobel_frame_ctrl: RTL and testbench

SOBEL_FRAME_CTRL -- requirements
Module: sobel_frame_ctrl

---
 rtl/sobel_frame_ctrl_pkg.sv | 12 +
 rtl/sobel_frame_ctrl_if.sv | 33 +++
 rtl/sobel_frame_ctrl_pos.sv | 50 +++++
 rtl/sobel_frame_ctrl.sv | 123 ++++++++++++
 tb/tb_sobel_frame_ctrl.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/sobel_frame_ctrl_pkg.sv
// Shared parameters and types for the sobel frame controller.
package sobel_frame_ctrl_pkg;

  localparam int MAX_PIXEL_BITS = 24;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DONE   = 2'd2
  } frame_state_e;

endpackage

// File: rtl/sobel_frame_ctrl_if.sv
// Pixel stream bundle between the sobel core, the frame controller and the downstream consumer.
interface sobel_frame_ctrl_if #(
  parameter int FRAME_COLS = 16,
  parameter int FRAME_ROWS = 16
);
  import sobel_frame_ctrl_pkg::*;

  localparam int CW = $clog2(FRAME_COLS);
  localparam int RW = $clog2(FRAME_ROWS);

  // Valid-only stream, no ready: a strobe high on a rising edge transfers the
  // data beside it in that same cycle, and the sink must take every beat.
  logic                      px_rdy_i;
  logic [MAX_PIXEL_BITS-1:0] px_i;
  logic                      px_rdy_o;
  logic [MAX_PIXEL_BITS-1:0] px_o;
  logic [CW-1:0]             col_o;
  logic [RW-1:0]             row_o;
  logic                      sof_o;
  logic                      eol_o;
  logic                      eof_o;

  modport slave (
    input  px_rdy_i, px_i,
    output px_rdy_o, px_o, col_o, row_o, sof_o, eol_o, eof_o
  );

  modport master (
    output px_rdy_i, px_i,
    input  px_rdy_o, px_o, col_o, row_o, sof_o, eol_o, eof_o
  );

endinterface

// File: rtl/sobel_frame_ctrl_pos.sv
// Column/row position counter; col_o/row_o give the position of the pixel accepted this cycle.
module frame_pos_counter #(
  parameter int COLS = 16,
  parameter int ROWS = 16,
  parameter int CW   = $clog2(COLS),
  parameter int RW   = $clog2(ROWS)
) (
  input  logic          clk_i,
  input  logic          nreset_i,
  input  logic          clear_i,
  input  logic          inc_i,
  output logic [CW-1:0] col_o,
  output logic [RW-1:0] row_o,
  output logic          col_last_o,
  output logic          row_last_o
);

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;

  // A clear coinciding with inc counts the incoming pixel as (0,0).
  assign col_o      = clear_i ? '0 : col_q;
  assign row_o      = clear_i ? '0 : row_q;
  assign col_last_o = (col_o == CW'(COLS - 1));
  assign row_last_o = (row_o == RW'(ROWS - 1));

  always_comb begin
    col_d = col_o;
    row_d = row_o;
    if (inc_i) begin
      if (col_last_o) begin
        col_d = '0;
        row_d = row_last_o ? '0 : row_o + RW'(1);
      end else begin
        col_d = col_o + CW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!nreset_i) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

endmodule

// File: rtl/sobel_frame_ctrl.sv
// Frame controller: tags the sobel pixel stream with position/frame flags and tracks frame completion.
module sobel_frame_ctrl
  import sobel_frame_ctrl_pkg::*;
#(
  parameter int FRAME_COLS = 16,
  parameter int FRAME_ROWS = 16
) (
  input  logic               clk_i,
  input  logic               nreset_i,
  input  logic               start_i,
  input  logic               clear_i,
  sobel_frame_ctrl_if.slave  px_if,
  output logic               frame_done_o,
  output logic               busy_o,
  output logic               err_o,
  output frame_state_e       state_o
);

  localparam int CW = $clog2(FRAME_COLS);
  localparam int RW = $clog2(FRAME_ROWS);

  frame_state_e              state_q, state_d;
  logic                      px_rdy_q, sof_q, eol_q, eof_q;
  logic [MAX_PIXEL_BITS-1:0] px_q, px_d;
  logic [CW-1:0]             col_q, col_d, pos_col;
  logic [RW-1:0]             row_q, row_d, pos_row;
  logic                      done_q, done_d;
  logic                      err_q, err_d;
  logic                      col_last, row_last;
  logic                      accept, at_eof;

  frame_pos_counter #(
    .COLS (FRAME_COLS),
    .ROWS (FRAME_ROWS),
    .CW   (CW),
    .RW   (RW)
  ) u_pos (
    .clk_i      (clk_i),
    .nreset_i   (nreset_i),
    .clear_i    (start_i),
    .inc_i      (accept),
    .col_o      (pos_col),
    .row_o      (pos_row),
    .col_last_o (col_last),
    .row_last_o (row_last)
  );

  // start_i opens the frame in the same cycle, so a coincident pixel is kept.
  assign accept = px_if.px_rdy_i && (start_i || (state_q == ST_ACTIVE));
  assign at_eof = col_last && row_last;

  always_comb begin
    state_d = state_q;
    done_d  = done_q;
    err_d   = err_q;
    px_d    = px_q;
    col_d   = col_q;
    row_d   = row_q;

    case (state_q)
      ST_IDLE:   if (start_i) state_d = ST_ACTIVE;
      ST_ACTIVE: state_d = ST_ACTIVE;
      ST_DONE: begin
        if (start_i)      state_d = ST_ACTIVE;
        else if (clear_i) state_d = ST_IDLE;
      end
      default:   state_d = ST_IDLE;
    endcase

    if (start_i || clear_i) done_d = 1'b0;
    if (clear_i)            err_d  = 1'b0;
    if (px_if.px_rdy_i && !accept) err_d = 1'b1;

    if (accept) begin
      px_d  = px_if.px_i;
      col_d = pos_col;
      row_d = pos_row;
      if (at_eof) begin
        state_d = ST_DONE;
        done_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!nreset_i) begin
      state_q  <= ST_IDLE;
      px_rdy_q <= 1'b0;
      px_q     <= '0;
      col_q    <= '0;
      row_q    <= '0;
      sof_q    <= 1'b0;
      eol_q    <= 1'b0;
      eof_q    <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      px_rdy_q <= accept;
      px_q     <= px_d;
      col_q    <= col_d;
      row_q    <= row_d;
      sof_q    <= accept && (pos_col == '0) && (pos_row == '0);
      eol_q    <= accept && col_last;
      eof_q    <= accept && at_eof;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  assign px_if.px_rdy_o = px_rdy_q;
  assign px_if.px_o     = px_q;
  assign px_if.col_o    = col_q;
  assign px_if.row_o    = row_q;
  assign px_if.sof_o    = sof_q;
  assign px_if.eol_o    = eol_q;
  assign px_if.eof_o    = eof_q;
  assign frame_done_o   = done_q;
  assign busy_o         = (state_q == ST_ACTIVE);
  assign err_o          = err_q;
  assign state_o        = state_q;

endmodule

// File: tb/tb_sobel_frame_ctrl.sv
// Bench for sobel_frame_ctrl: directed frame scenarios plus random traffic against a pixel-index model.
module tb_sobel_frame_ctrl;
  import sobel_frame_ctrl_pkg::*;

  localparam int C  = 4;
  localparam int R  = 3;
  localparam int PW = MAX_PIXEL_BITS;
  localparam int CW = $clog2(C);
  localparam int RW = $clog2(R);
  localparam int W  = 1 + PW + CW + RW + 6;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic nreset;
  logic start;
  logic clear;
  logic frame_done;
  logic busy;
  logic err;
  frame_state_e state;

  always #5 clk = ~clk;

  sobel_frame_ctrl_if #(.FRAME_COLS(C), .FRAME_ROWS(R)) px_if ();

  sobel_frame_ctrl #(.FRAME_COLS(C), .FRAME_ROWS(R)) dut (
    .clk_i        (clk),
    .nreset_i     (nreset),
    .start_i      (start),
    .clear_i      (clear),
    .px_if        (px_if.slave),
    .frame_done_o (frame_done),
    .busy_o       (busy),
    .err_o        (err),
    .state_o      (state)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Model: position is a linear pixel index within the frame.
  int            m_phase;  // 0 idle, 1 active, 2 done
  int            m_idx;
  bit            m_err, m_done;
  logic [PW-1:0] m_px;
  int            m_col, m_row;

  task automatic model_step(input bit rst_n, input bit st, input bit cl,
                            input bit vld, input logic [PW-1:0] d);
    bit acc, sof, eol, eof;
    acc = 0; sof = 0; eol = 0; eof = 0;
    if (!rst_n) begin
      m_phase = 0; m_idx = 0; m_err = 0; m_done = 0; m_px = '0; m_col = 0; m_row = 0;
    end else begin
      acc = vld && (st || m_phase == 1);
      if (st) begin
        m_phase = 1;
        m_idx   = 0;
      end else if (cl && m_phase == 2) begin
        m_phase = 0;
      end
      if (st || cl) m_done = 0;
      if (cl) m_err = 0;
      if (vld && !acc) m_err = 1;
      if (acc) begin
        m_px  = d;
        m_col = m_idx % C;
        m_row = m_idx / C;
        sof   = (m_idx == 0);
        eol   = (m_col == C - 1);
        eof   = (m_idx == C * R - 1);
        m_idx++;
        if (eof) begin
          m_phase = 2;
          m_done  = 1;
          m_idx   = 0;
        end
      end
    end
    exp_q.push_back({acc, m_px, CW'(m_col), RW'(m_row), sof, eol, eof,
                     m_done, m_err, (m_phase == 1)});
  endtask

  task automatic compare_out();
    logic [W-1:0] e;
    if (exp_q.size() == 0) begin
      check("exp_q_empty", 32'd1, 32'd0);
      return;
    end
    e = exp_q.pop_front();
    check("px_rdy",     32'(px_if.px_rdy_o), 32'(e[W-1]));
    check("px",         32'(px_if.px_o),     32'(e[W-2 -: PW]));
    check("col",        32'(px_if.col_o),    32'(e[W-2-PW -: CW]));
    check("row",        32'(px_if.row_o),    32'(e[W-2-PW-CW -: RW]));
    check("sof",        32'(px_if.sof_o),    32'(e[5]));
    check("eol",        32'(px_if.eol_o),    32'(e[4]));
    check("eof",        32'(px_if.eof_o),    32'(e[3]));
    check("frame_done", 32'(frame_done),     32'(e[2]));
    check("err",        32'(err),            32'(e[1]));
    check("busy",       32'(busy),           32'(e[0]));
  endtask

  // ---------------- driver ----------------
  task automatic cycle(input bit st, input bit cl, input bit vld,
                       input logic [PW-1:0] d, input bit rst_n = 1'b1);
    @(negedge clk);
    nreset         = rst_n;
    start          = st;
    clear          = cl;
    px_if.px_rdy_i = vld;
    px_if.px_i     = d;
    model_step(rst_n, st, cl, vld, d);
    @(posedge clk);
    #1;
    compare_out();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 0, 0, '0);
  endtask

  task automatic do_reset();
    cycle(0, 0, 0, '0, 1'b0);
    cycle(0, 0, 0, '0, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    nreset = 1'b0; start = 1'b0; clear = 1'b0;
    px_if.px_rdy_i = 1'b0; px_if.px_i = '0;

    do_reset();
    idle(1);

    // Full frame back to back
    cycle(1, 0, 0, '0);
    for (int i = 1; i <= C * R; i++) cycle(0, 0, 1, PW'(i));
    idle(2);
    check("done_hold", 32'(frame_done), 32'd1);

    // Same frame with one idle cycle between pixels
    cycle(1, 0, 0, '0);
    for (int i = 1; i <= C * R; i++) begin
      cycle(0, 0, 1, PW'(i));
      cycle(0, 0, 0, '0);
    end
    cycle(0, 1, 0, '0);
    idle(1);

    // Stray pixel in IDLE, then clear
    cycle(0, 0, 1, PW'('h55));
    check("err_set", 32'(err), 32'd1);
    cycle(0, 1, 0, '0);
    check("err_clr", 32'(err), 32'd0);

    // Restart mid-frame with a coincident pixel
    cycle(1, 0, 0, '0);
    for (int i = 1; i <= 5; i++) cycle(0, 0, 1, PW'(i));
    cycle(1, 0, 1, PW'('hAA));
    check("restart_sof", 32'(px_if.sof_o), 32'd1);
    for (int i = 1; i <= C * R - 1; i++) cycle(0, 0, 1, PW'(i + 'h10));
    check("restart_eof", 32'(px_if.eof_o), 32'd1);
    idle(1);

    // Reset mid-frame, then a fresh frame
    cycle(1, 0, 0, '0);
    for (int i = 1; i <= 6; i++) cycle(0, 0, 1, PW'(i));
    cycle(0, 0, 0, '0, 1'b0);
    cycle(1, 0, 1, PW'('h77));
    check("post_reset_col", 32'(px_if.col_o), 32'd0);
    for (int i = 1; i <= C * R - 1; i++) cycle(0, 0, 1, PW'(i));

    // In DONE: stray pixel sets err, then start+clear together
    cycle(0, 0, 1, PW'('h99));
    cycle(1, 1, 0, '0);
    check("sc_busy", 32'(busy), 32'd1);
    check("sc_done", 32'(frame_done), 32'd0);
    check("sc_err",  32'(err), 32'd0);
    idle(1);

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      cycle($urandom_range(0, 29) == 0, $urandom_range(0, 19) == 0,
            $urandom_range(0, 3) != 0, PW'($urandom),
            $urandom_range(0, 149) != 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
